// File: rtl/fadd_result_collector_pkg.sv
// Shared vector-ALU definitions for the float-add result collector.
// Holds the wave geometry constants and the collector state encoding.
package fadd_result_collector_pkg;

  localparam int LANES  = 32;  // lanes per wave
  localparam int LANE_W = 5;   // lane index width, log2(LANES)
  localparam int DATA_W = 32;  // result word width
  localparam int VDST_W = 8;   // destination VGPR index width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/fadd_result_collector_if.sv
// Bus bundle between the float adder / issue logic and the collector.
//   start, start_vdst, exec_mask        : instruction launch
//   in_valid/in_ready, in_lane, in_data,
//   in_nan, in_ovf                      : per-lane adder results
//   out_valid/out_ready, out_vdst,
//   out_lane, out_data                  : VGPR writeback beats
//   busy, done, nan_sticky, ovf_sticky,
//   dup_err                             : status
// master = the environment driving instructions and lane results and
// accepting writebacks; slave = the collector itself.
interface fadd_result_collector_if;
  import fadd_result_collector_pkg::*;

  logic              start;
  logic [VDST_W-1:0] start_vdst;
  logic [LANES-1:0]  exec_mask;
  logic              busy;

  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_lane;
  logic [DATA_W-1:0] in_data;
  logic              in_nan;
  logic              in_ovf;

  logic              out_valid;
  logic              out_ready;
  logic [VDST_W-1:0] out_vdst;
  logic [LANE_W-1:0] out_lane;
  logic [DATA_W-1:0] out_data;

  logic              done;
  logic              nan_sticky;
  logic              ovf_sticky;
  logic              dup_err;

  modport master (
    output start, start_vdst, exec_mask,
    output in_valid, in_lane, in_data, in_nan, in_ovf,
    output out_ready,
    input  busy, in_ready, out_valid, out_vdst, out_lane, out_data,
    input  done, nan_sticky, ovf_sticky, dup_err
  );

  modport slave (
    input  start, start_vdst, exec_mask,
    input  in_valid, in_lane, in_data, in_nan, in_ovf,
    input  out_ready,
    output busy, in_ready, out_valid, out_vdst, out_lane, out_data,
    output done, nan_sticky, ovf_sticky, dup_err
  );

endinterface

// File: rtl/fadd_result_collector_lane_pick.sv
// lane_pick: combinational lowest-set-bit priority encoder.
//   vec  : candidate lane vector (active and not yet drained)
//   idx  : index of the lowest set bit (0 when vec is empty)
//   any  : at least one bit of vec is set
module fadd_result_collector_lane_pick
  import fadd_result_collector_pkg::*;
#(
  parameter int LANES  = fadd_result_collector_pkg::LANES,
  parameter int LANE_W = fadd_result_collector_pkg::LANE_W
) (
  input  logic [LANES-1:0]  vec,
  output logic [LANE_W-1:0] idx,
  output logic              any
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (vec[i]) idx = LANE_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/fadd_result_collector.sv
// Float-add result collector.
// Captures one lane result per cycle for a wave add instruction, applies
// the exec mask, accumulates sticky NaN/overflow/duplicate status, then
// drains the active lanes in ascending order to the VGPR write port and
// pulses done.
//   clk   : clock
//   rst_n : asynchronous active-low reset (control state only)
//   bus   : slave side of fadd_result_collector_if
module fadd_result_collector
  import fadd_result_collector_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  fadd_result_collector_if.slave bus
);

  state_e            state_q, state_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [LANES-1:0]  rcvd_q, rcvd_d;
  logic [LANES-1:0]  drained_q, drained_d;
  logic [VDST_W-1:0] vdst_q, vdst_d;
  logic              nan_q, nan_d;
  logic              ovf_q, ovf_d;
  logic              dup_q, dup_d;

  // Result buffer carries no reset: every lane read is written first.
  logic [DATA_W-1:0] data_mem [LANES];
  logic              mem_we;

  logic [LANES-1:0]  pend;
  logic [LANES-1:0]  pick_onehot;
  logic [LANE_W-1:0] pick_idx;
  logic              pick_any;

  // Lanes still owed to the VGPR port; lowest one is presented next.
  assign pend = mask_q & ~drained_q;

  fadd_result_collector_lane_pick #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_pick (
    .vec (pend),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    rcvd_d    = rcvd_q;
    drained_d = drained_q;
    vdst_d    = vdst_q;
    nan_d     = nan_q;
    ovf_d     = ovf_q;
    dup_d     = dup_q;
    mem_we    = 1'b0;

    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d    = bus.exec_mask;
          vdst_d    = bus.start_vdst;
          rcvd_d    = '0;
          drained_d = '0;
          nan_d     = 1'b0;
          ovf_d     = 1'b0;
          dup_d     = 1'b0;
          state_d   = (bus.exec_mask == '0) ? ST_DONE : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (bus.in_valid) begin
          // Inactive lanes are consumed without touching data or status.
          if (mask_q[bus.in_lane]) begin
            mem_we               = 1'b1;
            rcvd_d[bus.in_lane]  = 1'b1;
            dup_d                = dup_q | rcvd_q[bus.in_lane];
            nan_d                = nan_q | bus.in_nan;
            ovf_d                = ovf_q | bus.in_ovf;
          end
          if (&(rcvd_d | ~mask_q)) state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (bus.out_ready && pick_any) begin
          drained_d = drained_q | pick_onehot;
          if ((pend & ~pick_onehot) == '0) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      rcvd_q    <= '0;
      drained_q <= '0;
      vdst_q    <= '0;
      nan_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      rcvd_q    <= rcvd_d;
      drained_q <= drained_d;
      vdst_q    <= vdst_d;
      nan_q     <= nan_d;
      ovf_q     <= ovf_d;
      dup_q     <= dup_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) data_mem[bus.in_lane] <= bus.in_data;
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.in_ready   = (state_q == ST_COLLECT);
  assign bus.out_valid  = (state_q == ST_DRAIN);
  assign bus.done       = (state_q == ST_DONE);
  // Pointer is derived from flops only, so it holds across stalls.
  assign bus.out_lane   = pick_idx;
  assign bus.out_data   = data_mem[pick_idx];
  assign bus.out_vdst   = vdst_q;
  assign bus.nan_sticky = nan_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.dup_err    = dup_q;

endmodule

// File: doc/fadd_result_collector.md
Name: fadd_result_collector

Overview:
- Sits directly downstream of the 32-bit float adder in the Vector ALU.
- Captures one lane result per cycle (sum word plus NaN/overflow flags) for a wave32 add instruction and applies the exec mask.
- Accumulates sticky exception status for the instruction.
- Drains the active-lane results in ascending lane order to the VGPR write port through a valid/ready handshake, then signals completion.

Parameters:
- LANES, 32, lanes per wave.
- LANE_W, 5, lane index width (log2 LANES).
- DATA_W, 32, result word width.
- VDST_W, 8, destination VGPR index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new instruction; accepted only in IDLE.
- start_vdst  in  VDST_W  destination VGPR, latched on accepted start.
- exec_mask  in  LANES  active-lane mask, latched on accepted start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  adder result present.
- in_ready  out  1  high only in COLLECT.
- in_lane  in  LANE_W  lane index of in_data.
- in_data  in  DATA_W  adder sum.
- in_nan  in  1  adder NaN_flag.
- in_ovf  in  1  adder overflow_flag.
- out_valid  out  1  writeback beat present.
- out_ready  in  1  VGPR port accepts the beat.
- out_vdst  out  VDST_W  latched destination.
- out_lane  out  LANE_W  lane being written.
- out_data  out  DATA_W  stored result for out_lane.
- done  out  1  one-cycle completion pulse.
- nan_sticky  out  1  OR of in_nan over accepted active lanes.
- ovf_sticky  out  1  OR of in_ovf over accepted active lanes.
- dup_err  out  1  sticky; an active lane was received twice.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, in_ready, out_valid, done, nan_sticky, ovf_sticky, dup_err are all 0.
  - Latched mask, received mask, out_vdst and out_lane are 0. The data buffer is not reset.
  - Reset mid-operation abandons the instruction with no done pulse.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - On start=1: latch start_vdst and exec_mask, clear received mask and all three sticky flags.
  - Next state is COLLECT. If exec_mask==0, next state is DONE instead.
  - start in any other state is ignored.
- COLLECT:
  - in_ready=1. A beat is accepted when in_valid=1 (in_ready is 1).
  - Active lane (mask bit 1): write in_data into buffer[in_lane], set received[in_lane], OR in_nan/in_ovf into the stickies.
  - Active lane already received: overwrite the data, set dup_err, OR in the flags.
  - Inactive lane: beat is consumed and discarded; no data or flag update.
  - Leave COLLECT in the cycle after an accept makes (received | ~mask) all ones; next state is DRAIN.
- DRAIN:
  - out_valid=1.
  - out_lane is the lowest-index active lane not yet drained; out_data = buffer[out_lane].
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On a handshake, mark that lane drained. If it was the last one, next state is DONE; otherwise the next lane is presented in the following cycle with no bubble.
- DONE:
  - done=1 for exactly one cycle, busy=1; next state is IDLE.
  - Stickies and dup_err hold their values until the next accepted start.
- Latency:
  - Last input accept at cycle t gives the first out_valid at t+1.
  - Last drain handshake at cycle u gives done at u+1 and IDLE at u+2.
  - Minimum instruction with 1 active lane and out_ready=1: start accepted at cycle 0, COLLECT 1, accept 1, DRAIN 2, DONE 3.

Decomposition:
- Shared vector-ALU package holds:
  - the LANES/LANE_W/DATA_W/VDST_W constants;
  - the state encoding (IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2, DONE=2'd3).
- One sub-module, lane_pick: a combinational lowest-set-bit priority encoder over (mask & ~drained). Outputs the index and an any-bit flag, and is reused by the DRAIN pointer logic.

Test Plan:
- Full mask 0xFFFFFFFF, lanes 0..31 in order with data=lane*0x01000000, flags 0, out_ready=1:
  - 32 beats, lanes 0..31 with matching data.
  - done 33 cycles after the last accept; stickies 0.
- Mask 0x00000005, lanes sent in order 2, 1, 0, with in_nan=1 on lane 1 only:
  - Beats for lane 0, then lane 2 only.
  - nan_sticky=0, because lane 1 is inactive.
- Mask 0x00000003, lane 0 sent twice (0x3F800000 then 0x40000000), then lane 1 with in_ovf=1:
  - dup_err=1, ovf_sticky=1.
  - Lane 0 drains 0x40000000.
- Mask 0x0000000F with out_ready toggled 0,1,0,0,1,1,0,1:
  - out_lane/out_data stay stable during stalls.
  - Exactly lanes 0,1,2,3 written, each once.
- Start with exec_mask=0: goes IDLE→DONE→IDLE with done=1, no out_valid. A second start during DONE is ignored.
- rst_n pulsed low in DRAIN after 2 of 4 beats: outputs cleared immediately, no done pulse. A fresh start then completes normally.
